// File: rtl/microc_pkg.sv
// ============================================================================
// Module  : microc_pkg
// Brief   : Shared opcodes, FSM states and control-word type for control_multiciclo.
// Revision: 1.0
// ============================================================================
`default_nettype none

package microc_pkg;

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_EXEC  = 2'd1,
      S_HALT  = 2'd2,
      S_WAIT  = 2'd3
   } state_t;

   localparam logic [5:0] OP_LI   = 6'b000000;
   localparam logic [5:0] OP_J    = 6'b010000;
   localparam logic [5:0] OP_JZ   = 6'b010001;
   localparam logic [5:0] OP_JNZ  = 6'b010010;
   localparam logic [5:0] OP_JC   = 6'b010011;
   localparam logic [5:0] OP_JNC  = 6'b010100;
   localparam logic [5:0] OP_SKZ  = 6'b010101;
   localparam logic [5:0] OP_SKNZ = 6'b010110;
   localparam logic [5:0] OP_HALT = 6'b011111;

   // ALU codes are carried straight from opcode[4:2]; ALU_NONE is driven otherwise.
   localparam logic [2:0] ALU_NONE = 3'b000;

   typedef struct packed {
      logic       s_skip;
      logic       s_inc;
      logic       s_inm;
      logic       we;
      logic [2:0] alu_op;
      logic       pc_en;
   } ctrl_t;

   localparam ctrl_t CTRL_IDLE = '{s_skip: 1'b0, s_inc: 1'b0, s_inm: 1'b0, we: 1'b0,
                                   alu_op: ALU_NONE, pc_en: 1'b0};

endpackage

`default_nettype wire

// File: rtl/uc_decoder.sv
// ============================================================================
// Module  : uc_decoder
// Brief   : Combinational opcode decoder producing the EXEC-cycle control word.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uc_decoder
   import microc_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic       z_flag,
   input  logic       c_flag,
   output ctrl_t      ctrl,
   output logic       is_alu,
   output logic       is_halt,
   output logic       illegal
);

   logic w_taken;

   always_comb begin
      ctrl    = CTRL_IDLE;
      is_alu  = 1'b0;
      is_halt = 1'b0;
      illegal = 1'b0;
      w_taken = 1'b0;
      if (opcode[5]) begin
         is_alu      = 1'b1;
         ctrl.alu_op = opcode[4:2];
         ctrl.we     = 1'b1;
         ctrl.s_inc  = 1'b1;
         ctrl.pc_en  = 1'b1;
      end else if (opcode[5:2] == OP_LI[5:2]) begin
         ctrl.s_inm = 1'b1;
         ctrl.we    = 1'b1;
         ctrl.s_inc = 1'b1;
         ctrl.pc_en = 1'b1;
      end else begin
         case (opcode)
            OP_J: ctrl.pc_en = 1'b1;
            OP_JZ, OP_JNZ, OP_JC, OP_JNC: begin
               case (opcode)
                  OP_JZ:   w_taken = z_flag;
                  OP_JNZ:  w_taken = ~z_flag;
                  OP_JC:   w_taken = c_flag;
                  default: w_taken = ~c_flag;
               endcase
               ctrl.s_inc = ~w_taken;
               ctrl.pc_en = 1'b1;
            end
            OP_SKZ, OP_SKNZ: begin
               ctrl.s_skip = (opcode == OP_SKZ) ? z_flag : ~z_flag;
               ctrl.s_inc  = 1'b1;
               ctrl.pc_en  = 1'b1;
            end
            OP_HALT: is_halt = 1'b1;
            default: begin
               ctrl.s_inc = 1'b1;
               ctrl.pc_en = 1'b1;
               illegal    = 1'b1;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/control_multiciclo.sv
// ============================================================================
// Module  : control_multiciclo
// Brief   : FETCH/EXEC control unit with flags, halt, illegal and retired count.
//           Define STEP_EN to add the single-step input and WAIT state.
// Revision: 1.0
// ============================================================================
`default_nettype none

module control_multiciclo
   import microc_pkg::*;
#(
   parameter int CNT_W = 16
)(
   input  logic             clk,
   input  logic             reset,
`ifdef STEP_EN
   input  logic             step,
`endif
   input  logic [5:0]       opcode,
   input  logic             zero_alu,
   input  logic             carry_alu,
   output logic             s_skip,
   output logic             s_inc,
   output logic             s_inm,
   output logic             we,
   output logic [2:0]       ALUOp,
   output logic             pc_en,
   output logic             z_flag,
   output logic             c_flag,
   output logic             halted,
   output logic             illegal,
   output logic [CNT_W-1:0] retired
);

   state_t           state_q, state_d;
   logic             z_q, z_d, c_q, c_d, ill_q, ill_d;
   logic [CNT_W-1:0] ret_q, ret_d;
   ctrl_t            w_dec_ctrl, w_ctrl;
   logic             w_is_alu, w_is_halt, w_illegal, w_exec;
`ifdef STEP_EN
   logic             step_q;
`endif

   uc_decoder u_dec (
      .opcode  (opcode),
      .z_flag  (z_q),
      .c_flag  (c_q),
      .ctrl    (w_dec_ctrl),
      .is_alu  (w_is_alu),
      .is_halt (w_is_halt),
      .illegal (w_illegal)
   );

   // Reset suppresses the EXEC commit so no write or PC update lands on a reset edge.
   assign w_exec = (state_q == S_EXEC) && !reset;
   assign w_ctrl = w_exec ? w_dec_ctrl : CTRL_IDLE;

   always_comb begin
      state_d = state_q;
      z_d     = z_q;
      c_d     = c_q;
      ill_d   = ill_q;
      ret_d   = ret_q;
      case (state_q)
         S_FETCH: state_d = S_EXEC;
         S_EXEC: begin
            if (w_is_halt) begin
               state_d = S_HALT;
            end else begin
`ifdef STEP_EN
               state_d = S_WAIT;
`else
               state_d = S_FETCH;
`endif
            end
            if (w_is_alu) begin
               z_d = zero_alu;
               c_d = carry_alu;
            end
            if (w_illegal) ill_d = 1'b1;
            if (ret_q != {CNT_W{1'b1}}) ret_d = ret_q + 1'b1;
         end
         S_HALT: state_d = S_HALT;
`ifdef STEP_EN
         S_WAIT: if (step && !step_q) state_d = S_FETCH;
`endif
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         z_q     <= 1'b0;
         c_q     <= 1'b0;
         ill_q   <= 1'b0;
         ret_q   <= '0;
`ifdef STEP_EN
         step_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         z_q     <= z_d;
         c_q     <= c_d;
         ill_q   <= ill_d;
         ret_q   <= ret_d;
`ifdef STEP_EN
         step_q  <= step;
`endif
      end
   end

   assign s_skip  = w_ctrl.s_skip;
   assign s_inc   = w_ctrl.s_inc;
   assign s_inm   = w_ctrl.s_inm;
   assign we      = w_ctrl.we;
   assign ALUOp   = w_ctrl.alu_op;
   assign pc_en   = w_ctrl.pc_en;
   assign z_flag  = z_q;
   assign c_flag  = c_q;
   assign halted  = (state_q == S_HALT);
   assign illegal = ill_q;
   assign retired = ret_q;

endmodule

`default_nettype wire

// File: tb/tb_control_multiciclo.sv
// ============================================================================
// Module  : tb_control_multiciclo
// Brief   : Randomized scoreboard bench for control_multiciclo (CNT_W=16 and CNT_W=2).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_control_multiciclo;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset = 1'b1;
   logic [5:0] opcode = '0;
   logic       zero_alu = 1'b0, carry_alu = 1'b0;
   logic       step_v = 1'b0;

   logic       s_skip, s_inc, s_inm, we, pc_en, z_flag, c_flag, halted, illegal;
   logic [2:0] ALUOp;
   logic [15:0] retired;
   logic       b_skip, b_inc, b_inm, b_we, b_pc_en, b_z, b_c, b_halted, b_illegal;
   logic [2:0] b_aluop;
   logic [1:0] b_retired;

`ifdef STEP_EN
   localparam bit STEP = 1'b1;
`else
   localparam bit STEP = 1'b0;
`endif

   control_multiciclo #(.CNT_W(16)) dut (
      .clk(clk), .reset(reset),
`ifdef STEP_EN
      .step(step_v),
`endif
      .opcode(opcode), .zero_alu(zero_alu), .carry_alu(carry_alu),
      .s_skip(s_skip), .s_inc(s_inc), .s_inm(s_inm), .we(we), .ALUOp(ALUOp),
      .pc_en(pc_en), .z_flag(z_flag), .c_flag(c_flag), .halted(halted),
      .illegal(illegal), .retired(retired)
   );

   control_multiciclo #(.CNT_W(2)) dut2 (
      .clk(clk), .reset(reset),
`ifdef STEP_EN
      .step(step_v),
`endif
      .opcode(opcode), .zero_alu(zero_alu), .carry_alu(carry_alu),
      .s_skip(b_skip), .s_inc(b_inc), .s_inm(b_inm), .we(b_we), .ALUOp(b_aluop),
      .pc_en(b_pc_en), .z_flag(b_z), .c_flag(b_c), .halted(b_halted),
      .illegal(b_illegal), .retired(b_retired)
   );

   typedef struct {
      logic [7:0] ctrl;   // {s_skip, s_inc, s_inm, we, ALUOp, pc_en}
      logic       z, c, h, ill;
      int         ret;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: instruction phase plus architectural status
   localparam int M_FETCH = 0, M_EXEC = 1, M_HALT = 2, M_WAIT = 3;
   int mode = M_FETCH;
   bit mz = 0, mc = 0, mill = 0, mprev = 0;
   int mret = 0;

   // Returns {illegal, s_skip, s_inc, s_inm, we, ALUOp, pc_en} for an EXEC cycle.
   function automatic logic [8:0] ref_ctrl(input logic [5:0] op, input bit z, input bit c);
      int k = int'(op);
      bit skip = 0, inc = 0, inm = 0, wen = 0, pc = 0, ill = 0, taken = 0;
      logic [2:0] alu = 3'b000;
      if (k >= 32) begin
         alu = op[4:2]; wen = 1; inc = 1; pc = 1;
      end else if (k < 4) begin
         inm = 1; wen = 1; inc = 1; pc = 1;
      end else if (k == 16) begin
         pc = 1;
      end else if (k >= 17 && k <= 20) begin
         taken = (k == 17) ? z : (k == 18) ? !z : (k == 19) ? c : !c;
         inc = !taken; pc = 1;
      end else if (k == 21 || k == 22) begin
         skip = (k == 21) ? z : !z; inc = 1; pc = 1;
      end else if (k == 31) begin
         pc = 0;
      end else begin
         inc = 1; pc = 1; ill = 1;
      end
      return {ill, skip, inc, inm, wen, alu, pc};
   endfunction

   task automatic cycle(input bit r, input logic [5:0] op, input bit za, input bit ca, input bit st);
      exp_t e;
      logic [8:0] d;
      @(posedge clk); #1;
      reset = r; opcode = op; zero_alu = za; carry_alu = ca; step_v = st;
      d = ref_ctrl(op, mz, mc);
      e.ctrl = (mode == M_EXEC && !r) ? d[7:0] : 8'h00;
      e.z = mz; e.c = mc; e.h = (mode == M_HALT); e.ill = mill; e.ret = mret;
      q.push_back(e);
      if (r) begin
         mode = M_FETCH; mz = 0; mc = 0; mill = 0; mret = 0; mprev = 0;
      end else begin
         case (mode)
            M_FETCH: mode = M_EXEC;
            M_EXEC: begin
               if (mret < 65535) mret++;
               if (op[5]) begin mz = za; mc = ca; end
               if (d[8]) mill = 1;
               mode = (op == 6'd31) ? M_HALT : (STEP ? M_WAIT : M_FETCH);
            end
            M_WAIT: if (st && !mprev) mode = M_FETCH;
            default: mode = mode;
         endcase
         mprev = st;
      end
   endtask

   // Advance through FETCH/WAIT until EXEC, then execute op (optionally under reset).
   task automatic run(input logic [5:0] op, input bit za, input bit ca, input bit rst_exec);
      for (int n = 0; n < 8 && mode != M_EXEC; n++)
         cycle(0, 6'($urandom), $urandom_range(0, 1), $urandom_range(0, 1), !mprev);
      cycle(rst_exec, op, za, ca, 1'b0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      int   sat;
      if (q.size() > 0) begin
         e = q.pop_front();
         checks++;
         if ({s_skip, s_inc, s_inm, we, ALUOp, pc_en} !== e.ctrl) begin
            errors++;
            $display("FAIL ctrl @%0t: got %b expected %b", $time,
                     {s_skip, s_inc, s_inm, we, ALUOp, pc_en}, e.ctrl);
         end
         checks++;
         if ({z_flag, c_flag} !== {e.z, e.c}) begin
            errors++;
            $display("FAIL flags @%0t: got z=%b c=%b expected z=%b c=%b", $time,
                     z_flag, c_flag, e.z, e.c);
         end
         checks++;
         if ({halted, illegal} !== {e.h, e.ill}) begin
            errors++;
            $display("FAIL status @%0t: got halted=%b illegal=%b expected halted=%b illegal=%b",
                     $time, halted, illegal, e.h, e.ill);
         end
         checks++;
         if (retired !== 16'(e.ret)) begin
            errors++;
            $display("FAIL retired @%0t: got %0d expected %0d", $time, retired, e.ret);
         end
         sat = (e.ret > 3) ? 3 : e.ret;
         checks++;
         if (b_retired !== 2'(sat)) begin
            errors++;
            $display("FAIL retired_w2 @%0t: got %0d expected %0d", $time, b_retired, sat);
         end
      end
   end

   initial begin
      repeat (2) @(posedge clk);
      cycle(1, 6'd0, 0, 0, 0);
      repeat (6) run(6'b000000, 0, 0, 0);
      run(6'b101000, 1, 1, 0);
      run(6'b000000, 0, 0, 0);
      run(6'b010001, 0, 0, 0);
      run(6'b100000, 0, 1, 0);
      run(6'b010001, 0, 0, 0);
      run(6'b010110, 0, 0, 0);
      run(6'b010011, 0, 0, 0);
      run(6'b011000, 0, 0, 0);
      run(6'b000001, 0, 0, 0);
      run(6'b011111, 0, 0, 0);
      repeat (20) cycle(0, 6'($urandom), 1, 1, $urandom_range(0, 1));
      cycle(1, 6'd0, 0, 0, 0);
      run(6'b111100, 1, 1, 0);
      run(6'b110100, 1, 0, 1);
      for (int i = 0; i < 2000; i++)
         cycle($urandom_range(0, 63) == 0, 6'($urandom), $urandom_range(0, 1),
               $urandom_range(0, 1), $urandom_range(0, 3) != 0);
      repeat (3) @(posedge clk);
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected entries left unchecked", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
